// File: rtl/bcd_cascade_counter_pkg.sv
// Shared types and constants for the cascaded BCD counter.
// Holds the run/stop state encoding, the decade limit and the digit width.
package bcd_cascade_counter_pkg;

  typedef enum logic {
    STOPPED = 1'b0,
    RUNNING = 1'b1
  } state_e;

  localparam int              DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;

  // Nibbles 10..15 are not legal BCD, so a preset saturates them to 9.
  function automatic logic [DIGIT_W-1:0] clampDigit(input logic [DIGIT_W-1:0] v);
    return (v > BCD_MAX) ? BCD_MAX : v;
  endfunction

endpackage

// File: rtl/bcd_cascade_counter_digit.sv
// One BCD decade: counts 0..9 up or down when enabled, with clear and preset.
// carry is combinational so a whole cascade ripples within a single cycle.
module bcd_digit
  import bcd_cascade_counter_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               up_dn,
  input  logic               clr,
  input  logic               load,
  input  logic [DIGIT_W-1:0] load_digit,
  output logic [DIGIT_W-1:0] q,
  output logic               carry
);

  logic [DIGIT_W-1:0] digit_q;
  logic [DIGIT_W-1:0] digit_d;

  always_comb begin
    digit_d = digit_q;
    if (clr) begin
      digit_d = '0;
    end else if (load) begin
      digit_d = clampDigit(load_digit);
    end else if (en) begin
      if (up_dn) begin
        digit_d = (digit_q == BCD_MAX) ? '0 : digit_q + 4'd1;
      end else begin
        digit_d = (digit_q == '0) ? BCD_MAX : digit_q - 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      digit_q <= '0;
    end else begin
      digit_q <= digit_d;
    end
  end

  // Carry on 9->0 when counting up, borrow on 0->9 when counting down.
  assign carry = en & (up_dn ? (digit_q == BCD_MAX) : (digit_q == '0));
  assign q     = digit_q;

endmodule

// File: rtl/bcd_cascade_counter.sv
// Cascaded BCD counter stepped once per rising edge of tick_in while RUNNING.
// Provides clear, saturating preset, a full-range wrap pulse and a sticky overflow.
module bcd_cascade_counter
  import bcd_cascade_counter_pkg::*;
#(
  parameter int NUM_DIGITS = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          tick_in,
  input  logic                          start,
  input  logic                          stop,
  input  logic                          up_dn,
  input  logic                          clr,
  input  logic                          load,
  input  logic [DIGIT_W*NUM_DIGITS-1:0] load_val,
  output logic [DIGIT_W*NUM_DIGITS-1:0] digits,
  output logic                          carry_out,
  output logic                          overflow,
  output logic                          running
);

  state_e            state_q;
  state_e            state_d;
  logic              tickPrev_q;
  logic              carryOut_q;
  logic              carryOut_d;
  logic              overflow_q;
  logic              overflow_d;
  logic              step;
  logic              wrap;
  logic [NUM_DIGITS:0] chain;

  always_comb begin
    state_d = state_q;
    case (state_q)
      STOPPED: if (start && !stop) state_d = RUNNING;
      RUNNING: if (stop) state_d = STOPPED;
    endcase
  end

  // The registered state gates step, so start lags one edge and stop still lets its tick through.
  assign step     = tick_in & ~tickPrev_q & (state_q == RUNNING);
  assign chain[0] = step;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : gDigit
    bcd_digit uDigit (
      .clk        (clk),
      .rst        (rst),
      .en         (chain[g]),
      .up_dn      (up_dn),
      .clr        (clr),
      .load       (load),
      .load_digit (load_val[g*DIGIT_W +: DIGIT_W]),
      .q          (digits[g*DIGIT_W +: DIGIT_W]),
      .carry      (chain[g+1])
    );
  end

  // clr and load override the step inside every digit, so they also mask the wrap.
  assign wrap = chain[NUM_DIGITS] & ~clr & ~load;

  always_comb begin
    carryOut_d = wrap;
    overflow_d = clr ? 1'b0 : (overflow_q | wrap);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= STOPPED;
      tickPrev_q <= 1'b0;
      carryOut_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tickPrev_q <= tick_in;
      carryOut_q <= carryOut_d;
      overflow_q <= overflow_d;
    end
  end

  assign carry_out = carryOut_q;
  assign overflow  = overflow_q;
  assign running   = (state_q == RUNNING);

endmodule

// File: tb/tb_bcd_cascade_counter.sv
// Bench for bcd_cascade_counter: directed scenarios followed by random traffic,
// all checked against an integer-valued model of the decimal count.
module tb_bcd_cascade_counter;

  localparam int ND   = 4;
  localparam int W    = 4 * ND;
  localparam int MODV = 10000;

  logic         clk = 1'b0;
  logic         rst, tickIn, start, stop, upDn, clr, load;
  logic [W-1:0] loadVal;
  logic [W-1:0] digits;
  logic         carryOut, overflow, running;

  int total = 0;
  int bad   = 0;

  int mCount;
  bit mRun, mTickPrev, mCarry, mOvf;

  bcd_cascade_counter #(.NUM_DIGITS(ND)) dut (
    .clk       (clk),
    .rst       (rst),
    .tick_in   (tickIn),
    .start     (start),
    .stop      (stop),
    .up_dn     (upDn),
    .clr       (clr),
    .load      (load),
    .load_val  (loadVal),
    .digits    (digits),
    .carry_out (carryOut),
    .overflow  (overflow),
    .running   (running)
  );

  always #5 clk = ~clk;

  function automatic int decodeLoad(input logic [W-1:0] v);
    int acc, scale, nib;
    acc = 0;
    scale = 1;
    for (int i = 0; i < ND; i++) begin
      nib = int'(v[i*4 +: 4]);
      if (nib > 9) nib = 9;
      acc += nib * scale;
      scale *= 10;
    end
    return acc;
  endfunction

  function automatic logic [W-1:0] toBcd(input int n);
    logic [W-1:0] r;
    int x;
    r = '0;
    x = n;
    for (int i = 0; i < ND; i++) begin
      r[i*4 +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drives one clock's worth of inputs, advances the model, then compares after the edge.
  task automatic applyStimulus(input logic r, input logic c, input logic l, input logic [W-1:0] v,
                               input logic s, input logic p, input logic u, input logic t);
    bit stepNow;
    rst = r; clr = c; load = l; loadVal = v; start = s; stop = p; upDn = u; tickIn = t;
    if (r) begin
      mCount = 0; mRun = 0; mTickPrev = 0; mCarry = 0; mOvf = 0;
    end else begin
      stepNow = t && !mTickPrev && mRun;
      mCarry  = 0;
      if (c) begin
        mCount = 0;
        mOvf   = 0;
      end else if (l) begin
        mCount = decodeLoad(v);
      end else if (stepNow) begin
        if (u) begin
          if (mCount == MODV - 1) begin mCount = 0; mCarry = 1; mOvf = 1; end
          else mCount++;
        end else begin
          if (mCount == 0) begin mCount = MODV - 1; mCarry = 1; mOvf = 1; end
          else mCount--;
        end
      end
      mRun      = mRun ? !p : (s && !p);
      mTickPrev = t;
    end
    @(posedge clk);
    #1;
    checkOutput("digits",   32'(digits),   32'(toBcd(mCount)));
    checkOutput("carryOut", 32'(carryOut), 32'(mCarry));
    checkOutput("overflow", 32'(overflow), 32'(mOvf));
    checkOutput("running",  32'(running),  32'(mRun));
  endtask

  initial begin
    logic sawCarry;
    logic r, c, l, s, p, u, t;
    logic [W-1:0] v;

    rst = 1'b1; clr = 1'b0; load = 1'b0; loadVal = '0;
    start = 1'b0; stop = 1'b0; upDn = 1'b1; tickIn = 1'b0;
    mCount = 0; mRun = 0; mTickPrev = 0; mCarry = 0; mOvf = 0;

    // Reset, start, ten rising ticks upward
    applyStimulus(1, 0, 0, '0, 0, 0, 1, 0);
    checkOutput("resetDigits", 32'(digits), 32'h0);
    checkOutput("resetRunning", 32'(running), 32'h0);
    applyStimulus(0, 0, 0, '0, 1, 0, 1, 0);
    sawCarry = 1'b0;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(0, 0, 0, '0, 0, 0, 1, 1);
      sawCarry |= carryOut;
      applyStimulus(0, 0, 0, '0, 0, 0, 1, 0);
      sawCarry |= carryOut;
    end
    checkOutput("tenTicks", 32'(digits), 32'h0010);
    checkOutput("tenTicksNoCarry", 32'(sawCarry), 32'h0);

    // Up wrap from 9998
    applyStimulus(0, 0, 1, 16'h9998, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, '0, 0, 0, 1, 1);
    checkOutput("upTo9999", 32'(digits), 32'h9999);
    applyStimulus(0, 0, 0, '0, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, '0, 0, 0, 1, 1);
    checkOutput("upWrapDigits", 32'(digits), 32'h0000);
    checkOutput("upWrapCarry", 32'(carryOut), 32'h1);
    checkOutput("upWrapOvf", 32'(overflow), 32'h1);
    applyStimulus(0, 0, 0, '0, 0, 0, 1, 0);
    checkOutput("upCarryOneCycle", 32'(carryOut), 32'h0);

    // Down wrap from 0001
    applyStimulus(0, 1, 0, '0, 0, 0, 0, 0);
    checkOutput("clrOvf", 32'(overflow), 32'h0);
    applyStimulus(0, 0, 1, 16'h0001, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, '0, 0, 0, 0, 1);
    checkOutput("downTo0000", 32'(digits), 32'h0000);
    applyStimulus(0, 0, 0, '0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, '0, 0, 0, 0, 1);
    checkOutput("downWrapDigits", 32'(digits), 32'h9999);
    checkOutput("downWrapCarry", 32'(carryOut), 32'h1);
    checkOutput("downWrapOvf", 32'(overflow), 32'h1);
    applyStimulus(0, 0, 0, '0, 0, 0, 0, 0);

    // Tick held high for 20 cycles gives one step
    applyStimulus(0, 1, 0, '0, 0, 0, 1, 0);
    applyStimulus(0, 0, 1, 16'h0100, 0, 0, 1, 0);
    for (int i = 0; i < 20; i++) applyStimulus(0, 0, 0, '0, 0, 0, 1, 1);
    applyStimulus(0, 0, 0, '0, 0, 0, 1, 0);
    checkOutput("heldTick", 32'(digits), 32'h0101);

    // clr beats load beats a tick rise
    applyStimulus(0, 0, 1, 16'h9999, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, '0, 0, 0, 1, 1);
    applyStimulus(0, 0, 0, '0, 0, 0, 1, 0);
    checkOutput("preClrOvf", 32'(overflow), 32'h1);
    applyStimulus(0, 1, 1, 16'h1234, 0, 0, 1, 1);
    checkOutput("clrWinsDigits", 32'(digits), 32'h0000);
    checkOutput("clrWinsOvf", 32'(overflow), 32'h0);
    applyStimulus(0, 0, 0, '0, 0, 0, 1, 0);

    // Saturating load, then reset mid-run blocks further steps
    applyStimulus(0, 0, 1, 16'hFA37, 0, 0, 1, 0);
    checkOutput("loadClamp", 32'(digits), 32'h9937);
    applyStimulus(1, 0, 0, '0, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, '0, 0, 0, 1, 1);
    checkOutput("postRstDigits", 32'(digits), 32'h0000);
    checkOutput("postRstRunning", 32'(running), 32'h0);
    applyStimulus(0, 0, 0, '0, 0, 0, 1, 0);

    // Tick rise with start is ignored; tick rise with stop counts
    applyStimulus(0, 0, 0, '0, 1, 0, 1, 1);
    checkOutput("startEdgeNoStep", 32'(digits), 32'h0000);
    applyStimulus(0, 0, 0, '0, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, '0, 0, 1, 1, 1);
    checkOutput("stopEdgeStep", 32'(digits), 32'h0001);
    checkOutput("stopEdgeRunning", 32'(running), 32'h0);
    applyStimulus(0, 0, 0, '0, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, '0, 1, 1, 1, 1);
    checkOutput("stopWinsStart", 32'(running), 32'h0);
    applyStimulus(0, 0, 0, '0, 0, 0, 1, 0);

    // Random traffic
    u = 1'b1;
    t = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      r = ($urandom_range(127) == 0);
      c = ($urandom_range(63) == 0);
      l = ($urandom_range(15) == 0);
      s = ($urandom_range(7) == 0);
      p = ($urandom_range(31) == 0);
      if ($urandom_range(15) == 0) u = ~u;
      if ($urandom_range(2) == 0) t = ~t;
      case ($urandom_range(3))
        0:       v = 16'h9999;
        1:       v = 16'h0000;
        default: v = 16'($urandom);
      endcase
      applyStimulus(r, c, l, v, s, p, u, t);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bcd_cascade_counter.md
BCD_CASCADE_COUNTER -- requirements
Module: bcd_cascade_counter

Interface
REQ-001 The block SHALL have parameter NUM_DIGITS, default 4, meaning the number of cascaded BCD decades (range 1..8).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: the synchronous, active-high reset.
REQ-004 The block SHALL have port tick_in, input, 1 bit: the divided-clock waveform from the upstream divide-by-10 stage, sampled in the clk domain.
REQ-005 The block SHALL have port start, input, 1 bit: a run-command pulse.
REQ-006 The block SHALL have port stop, input, 1 bit: a halt-command pulse.
REQ-007 The block SHALL have port up_dn, input, 1 bit: count direction, 1 = up and 0 = down.
REQ-008 The block SHALL have port clr, input, 1 bit: a synchronous clear of the digits and of overflow.
REQ-009 The block SHALL have port load, input, 1 bit, with load_val, input, 4*NUM_DIGITS bits: a preset strobe and its packed BCD value, digit 0 in the LSBs.
REQ-010 The block SHALL have port digits, output, 4*NUM_DIGITS bits: the current packed BCD count.
REQ-011 The block SHALL have port carry_out, output, 1 bit: a one-cycle pulse on full-range wrap.
REQ-012 The block SHALL have port overflow, output, 1 bit, sticky: at least one wrap has occurred since the last clr or rst.
REQ-013 The block SHALL have port running, output, 1 bit: high when the FSM is in RUNNING.

Function
REQ-014 The block SHALL register tick_in into tick_d every cycle.
REQ-015 The block SHALL form step = tick_in & ~tick_d & (state == RUNNING), so exactly one step occurs per rising edge of tick_in, regardless of its high time.
REQ-016 The FSM SHALL have states STOPPED and RUNNING, and SHALL reset to STOPPED.
REQ-017 FSM transitions SHALL be: start && !stop in STOPPED goes to RUNNING; stop in RUNNING goes to STOPPED; start and stop asserted together leave or put the FSM in STOPPED (stop wins).
REQ-018 step SHALL use the registered state, so a tick rise coinciding with stop still counts, and a tick rise coinciding with start does not.
REQ-019 Operation priority per edge SHALL be rst > clr > load > step.
REQ-020 clr and load SHALL be honoured in either state and SHALL NOT change the FSM state.
REQ-021 clr SHALL set digits to 0, clear overflow, and force carry_out to 0 that cycle.
REQ-022 load SHALL copy load_val into digits, and each nibble greater than 9 SHALL be loaded as 9.
REQ-023 load SHALL leave overflow unchanged and force carry_out to 0.
REQ-024 On an up step, digit 0 SHALL increment; a digit at 9 SHALL become 0 and carry into the next digit; an all-9s count SHALL become all-0s.
REQ-025 On a down step, digit 0 SHALL decrement; a digit at 0 SHALL become 9 and borrow from the next digit; an all-0s count SHALL become all-9s.
REQ-026 On either full-range wrap, carry_out SHALL be 1 for exactly the cycle following the wrapping edge, and overflow SHALL be set.
REQ-027 digits, carry_out and overflow SHALL be registered outputs, with 1-cycle latency from the sampled tick rise to the updated digits.
REQ-028 Each digit SHALL remain within 0..9 at all times, with no binary values above 9 visible on digits.
REQ-029 A change of up_dn SHALL take effect on the next step, with no other side effect.

Reset
REQ-030 rst, when sampled high on a rising clk edge, SHALL set digits to 0, carry_out to 0, overflow to 0, tick_d to 0, and the FSM to STOPPED.
REQ-031 rst asserted mid-run SHALL override every other input in that cycle.
REQ-032 After rst is released, no step SHALL occur until a start has been accepted.

Structure
REQ-033 A shared package SHALL hold the state enum (STOPPED, RUNNING), the constant BCD_MAX = 9, and the digit width of 4.
REQ-034 A sub-module bcd_digit SHALL implement one decade, with inputs en, up_dn, clr, load, and load_digit, and outputs q[3:0] and carry/borrow.
REQ-035 bcd_digit SHALL be instantiated NUM_DIGITS times, with the carry of each digit chained into the en of the next.

Verification
REQ-036 The bench SHALL cover: rst, then start, then 10 tick_in rises with up_dn=1 -> digits = 0x0010, carry_out never 1.
REQ-037 The bench SHALL cover: load 0x9998, start, up, 2 rises -> 0x9999 then 0x0000, carry_out high for 1 cycle, overflow = 1.
REQ-038 The bench SHALL cover: load 0x0001, up_dn=0, 2 rises -> 0x0000 then 0x9999, carry_out pulse, overflow = 1.
REQ-039 The bench SHALL cover: tick_in held high for 20 cycles while RUNNING -> exactly one step.
REQ-040 The bench SHALL cover: clr, load 0x1234 and a tick rise in the same cycle -> digits = 0x0000, overflow = 0.
REQ-041 The bench SHALL cover: load 0xFA37 -> 0x9937; then rst mid-run followed by a tick rise with no start -> digits stay 0x0000 and running = 0.
